// File: rtl/neuron_v3.sv
// Fixed-point neuron: multiply-accumulate over LANES-wide beats, bias, saturate, optional ReLU.
// Latency: out_valid rises 2 edges after the edge that accepts the last beat. Backpressure: in_ready low outside IDLE/ACCUM, result held until out_ready.
// Optional feature: define NEURON_ROUND_EN for round-half-up in SAT (default build truncates).
module neuron_v3 #(
    parameter int N      = 10,
    parameter int Q      = 9,
    parameter int LANES  = 4,
    parameter int FAN_IN = 16,
    parameter int GUARD  = 4,
    parameter int ACT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   w,
    input  logic [LANES*N-1:0]   x,
    input  logic [N-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out,
    output logic                 ovf
);

    localparam int AW    = 2*N + GUARD + $clog2(LANES);
    localparam int BEATS = FAN_IN / LANES;
    localparam int CW    = $clog2(BEATS + 1);

    // Clamp bounds at the widened shift width so comparisons stay signed and exact.
    localparam logic signed [AW:0] MAXV = $signed({{(AW+1-N){1'b0}}, 1'b0, {(N-1){1'b1}}});
    localparam logic signed [AW:0] MINV = $signed({{(AW+1-N){1'b1}}, 1'b1, {(N-1){1'b0}}});

    typedef enum logic [2:0] {IDLE, ACCUM, BIAS, SAT, OUT} state_t;

    state_t state, state_nxt;

    logic signed [AW-1:0]  acc;
    logic signed [N-1:0]   b_reg;
    logic [CW-1:0]         cnt;
    logic                  accept;

    logic signed [2*N-1:0] prod [LANES];
    logic signed [AW-1:0]  lane_sum;
    logic signed [AW-1:0]  bias_sh;
    logic signed [AW:0]    rnd;
    logic signed [AW:0]    shifted;
    logic [N-1:0]          sat_val;
    logic                  sat_ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (BEATS == 1) ? BIAS : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == CW'(BEATS - 1)) state_nxt = BIAS;
            end
            BIAS: state_nxt = SAT;
            SAT:  state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            prod[k]  = (2*N)'($signed(w[k*N +: N])) * (2*N)'($signed(x[k*N +: N]));
            lane_sum = lane_sum + AW'(prod[k]);
        end
    end

    assign bias_sh = AW'(b_reg) <<< Q;

    always_comb begin
`ifdef NEURON_ROUND_EN
        rnd = (AW+1)'(acc) + ((AW+1)'(1) <<< (Q - 1));
`else
        rnd = (AW+1)'(acc);
`endif
        shifted = rnd >>> Q;
        sat_ovf = 1'b0;
        sat_val = shifted[N-1:0];
        if (shifted > MAXV) begin
            sat_val = {1'b0, {(N-1){1'b1}}};
            sat_ovf = 1'b1;
        end else if (shifted < MINV) begin
            sat_val = {1'b1, {(N-1){1'b0}}};
            sat_ovf = 1'b1;
        end
        // ReLU is applied after clamping so ovf still reports the clamp.
        if (ACT == 1 && sat_val[N-1]) sat_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            b_reg <= '0;
            out   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc   <= lane_sum;
                    b_reg <= $signed(b);
                    cnt   <= CW'(1);
                end
                ACCUM: if (accept) begin
                    acc <= acc + lane_sum;
                    cnt <= cnt + CW'(1);
                end
                BIAS: acc <= acc + bias_sh;
                SAT: begin
                    out <= sat_val;
                    ovf <= sat_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_v3.sv
// Directed table-driven bench for neuron_v3 (identity and ReLU instances side by side).
module tb_neuron_v3;

    localparam int N = 10;
    localparam int LANES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [LANES*N-1:0] w, x;
    logic [N-1:0]     b;
    logic             in_ready, out_valid, ovf;
    logic [N-1:0]     out;
    logic             in_ready_r, out_valid_r, ovf_r;
    logic [N-1:0]     out_r;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    neuron_v3 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .w(w), .x(x), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovf(ovf)
    );

    neuron_v3 #(.ACT(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .w(w), .x(x), .b(b), .out_valid(out_valid_r), .out_ready(out_ready),
        .out(out_r), .ovf(ovf_r)
    );

    typedef struct {
        int w;    // weight for the first n products
        int x;    // activation for the first n products
        int n;    // number of nonzero products (0..16)
        int b;
        int eo;   // expected out, identity
        int ev;   // expected ovf (both instances)
        int ro;   // expected out, ReLU
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input vec_t v, input int beat);
        for (int l = 0; l < LANES; l++) begin
            if (beat*LANES + l < v.n) begin
                w[l*N +: N] = N'(v.w);
                x[l*N +: N] = N'(v.x);
            end else begin
                w[l*N +: N] = '0;
                x[l*N +: N] = '0;
            end
        end
        b = N'(v.b);
        in_valid = 1'b1;
    endtask

    // Feeds 4 beats, checks the 2-edge latency and the result; leaves the DUT in OUT.
    task automatic feed(input vec_t v, input int gap, input string tag);
        for (int bt = 0; bt < 4; bt++) begin
            drive_beat(v, bt);
            tick();
            in_valid = 1'b0;
            w = '0;
            x = '0;
            if (bt < 3) repeat (gap) tick();
        end
        chk({tag, ".lat0"}, int'(out_valid), 0);
        tick();
        chk({tag, ".lat1"}, int'(out_valid), 0);
        tick();
        chk({tag, ".lat2"}, int'(out_valid), 1);
        chk({tag, ".out"}, int'($signed(out)), v.eo);
        chk({tag, ".ovf"}, int'(ovf), v.ev);
        chk({tag, ".relu_out"}, int'($signed(out_r)), v.ro);
        chk({tag, ".relu_ovf"}, int'(ovf_r), v.ev);
    endtask

    task automatic drain(input vec_t v, input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle_vld"}, int'(out_valid), 0);
        chk({tag, ".idle_rdy"}, int'(in_ready), 1);
        chk({tag, ".retain"}, int'($signed(out)), v.eo);
    endtask

    initial begin
        vec_t v2, junk;
        int   rnd_pos, rnd_neg;
`ifdef NEURON_ROUND_EN
        rnd_pos = 1;  rnd_neg = 0;
`else
        rnd_pos = 0;  rnd_neg = -1;
`endif
        //          w     x    n   b     eo       ev  ro
        tbl[0] = '{   0,    0,  0,  128,  128,     0, 128};
        tbl[1] = '{ 256,  256,  1,    0,  128,     0, 128};
        tbl[2] = '{ 256,  256, 16,    0,  511,     1, 511};
        tbl[3] = '{-256,  256, 16,    0, -512,     1,   0};
        tbl[4] = '{  16,   16,  1,    0, rnd_pos,  0, rnd_pos};
        tbl[5] = '{ -16,   16,  1,    0, rnd_neg,  0, 0};
        tbl[6] = '{ 128,  128,  8, -100,  156,     0, 156};
        tbl[7] = '{   0,    0,  0,  511,  511,     0, 511};
        tbl[8] = '{   0,    0,  0, -512, -512,     0,   0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        w = '0; x = '0; b = '0;
        tick();
        tick();
        chk("reset.out", int'(out), 0);
        chk("reset.ovf", int'(ovf), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.in_ready", int'(in_ready), 1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            feed(tbl[i], 0, $sformatf("vec%0d", i));
            drain(tbl[i], $sformatf("vec%0d", i));
        end

        // Result held under backpressure while in_valid is asserted with junk.
        v2 = tbl[1];
        junk = tbl[2];
        feed(v2, 0, "hold");
        for (int c = 0; c < 5; c++) begin
            drive_beat(junk, 0);
            tick();
            chk("hold.out", int'($signed(out)), 128);
            chk("hold.ovf", int'(ovf), 0);
            chk("hold.in_ready", int'(in_ready), 0);
            chk("hold.out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        drain(v2, "hold");

        // Reset mid-evaluation discards partial state.
        drive_beat(junk, 0);
        tick();
        drive_beat(junk, 1);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.in_ready", int'(in_ready), 1);
        chk("midrst.out_valid", int'(out_valid), 0);
        chk("midrst.out", int'(out), 0);
        feed(v2, 0, "after_rst");
        drain(v2, "after_rst");

        feed(v2, 3, "gaps");
        drain(v2, "gaps");
        feed(tbl[6], 2, "gaps6");
        drain(tbl[6], "gaps6");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
